// File: rtl/instruction_loader.sv
// Manual instruction entry: debounced buttons assemble hex nibbles
// into 32-bit words written to instruction memory via valid/ready.

// Synchronizer + debouncer producing one pulse per accepted press
module il_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1
                     : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          stable;
   logic          stable_q;

   // Two-flop synchronizer for the raw asynchronous button
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= 2'b00;
      end else begin
         sync <= {sync[0], btn};
      end
   end

   // Stable level moves only after a full run of differing samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (sync[1] != stable) begin
         if (cnt == LAST) begin
            stable <= sync[1];
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

   // Registered rising-edge detect of the stable level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_q <= 1'b0;
         pulse    <= 1'b0;
      end else begin
         stable_q <= stable;
         pulse    <= stable & ~stable_q;
      end
   end

endmodule

// Entry FSM: ENTRY collects nibbles, WRITE holds the memory request,
// FULL blocks entry once the last address has been written
module instruction_loader #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int ADDR_WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            hex_in,
   input  logic                  btn_push,
   input  logic                  btn_clear,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_data,
   output logic [31:0]           word_out,
   output logic [2:0]            nibble_cnt,
   output logic                  full
);

   typedef enum logic [1:0] {
      ENTRY = 2'd0,
      WRITE = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

   state_t      state;
   logic        push_p;
   logic        clear_p;
   logic [31:0] word_next;

   il_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_push (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_push),
      .pulse (push_p)
   );

   il_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_clear (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_clear),
      .pulse (clear_p)
   );

   assign word_next = {word_out[27:0], hex_in};

   // Entry/write/full sequencing with all outputs registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ENTRY;
         mem_valid  <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         word_out   <= '0;
         nibble_cnt <= '0;
         full       <= 1'b0;
      end else begin
         unique case (state)
            ENTRY: begin
               if (clear_p) begin
                  word_out   <= '0;
                  nibble_cnt <= '0;
               end else if (push_p) begin
                  word_out <= word_next;
                  if (nibble_cnt == 3'd7) begin
                     mem_data   <= word_next;
                     nibble_cnt <= '0;
                     mem_valid  <= 1'b1;
                     state      <= WRITE;
                  end else begin
                     nibble_cnt <= nibble_cnt + 3'd1;
                  end
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  word_out  <= '0;
                  if (mem_addr == ADDR_MAX) begin
                     full  <= 1'b1;
                     state <= FULL;
                  end else begin
                     mem_addr <= mem_addr + 1'b1;
                     state    <= ENTRY;
                  end
               end
            end
            FULL: begin
               if (clear_p) begin
                  mem_addr   <= '0;
                  word_out   <= '0;
                  nibble_cnt <= '0;
                  full       <= 1'b0;
                  state      <= ENTRY;
               end
            end
            default: begin
               state <= ENTRY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader with directed entry vectors.
// Writes are checked by a monitor; entry state is checked inline.

module tb_instruction_loader;

   localparam int DB = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    hex_in;
   logic          btn_push;
   logic          btn_clear;
   logic          mem_valid;
   logic          mem_ready;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_data;
   logic [31:0]   word_out;
   logic [2:0]    nibble_cnt;
   logic          full;

   int checks    = 0;
   int failures  = 0;
   int hs_count  = 0;
   int vld_count = 0;

   logic [AW+31:0] sb_q[$];

   instruction_loader #(
      .DEBOUNCE_CYCLES(DB),
      .ADDR_WIDTH     (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .hex_in     (hex_in),
      .btn_push   (btn_push),
      .btn_clear  (btn_clear),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .word_out   (word_out),
      .nibble_cnt (nibble_cnt),
      .full       (full)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every handshake pops and compares one expected write
   always @(negedge clk) begin
      if (!rst && mem_valid) begin
         vld_count++;
         if (mem_ready) begin
            hs_count++;
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL write_unexpected: got %0h/%0h expected none",
                        mem_addr, mem_data);
            end else begin
               logic [AW+31:0] e;
               e = sb_q.pop_front();
               if ({mem_addr, mem_data} !== e) begin
                  failures++;
                  $display("FAIL write: got %0h/%0h expected %0h/%0h",
                           mem_addr, mem_data, e[AW+31:32], e[31:0]);
               end
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] h);
      hex_in   = h;
      btn_push = 1'b1;
      cyc(12);
      btn_push = 1'b0;
      cyc(12);
   endtask

   task automatic press_clear();
      btn_clear = 1'b1;
      cyc(12);
      btn_clear = 1'b0;
      cyc(12);
   endtask

   task automatic enter_word(input logic [31:0] w);
      for (int i = 7; i >= 0; i--) press(w[i*4 +: 4]);
   endtask

   initial begin
      int v0;
      rst       = 1'b1;
      hex_in    = 4'h0;
      btn_push  = 1'b0;
      btn_clear = 1'b0;
      mem_ready = 1'b1;
      cyc(3);
      check("rst_outputs",
            {mem_valid, mem_addr, full, nibble_cnt},
            64'd0);
      check("rst_data", {mem_data, word_out}, 64'd0);
      rst = 1'b0;
      cyc(2);

      // Basic word: addi x1, x0, 5
      v0 = vld_count;
      sb_q.push_back({2'd0, 32'h00500093});
      enter_word(32'h00500093);
      check("s1_valid_cycles", vld_count - v0, 1);
      check("s1_addr", mem_addr, 1);
      check("s1_word", word_out, 0);
      check("s1_cnt", nibble_cnt, 0);

      // Bouncing button then a long hold: exactly one nibble
      hex_in = 4'h1;
      for (int i = 0; i < 10; i++) begin
         btn_push = ~btn_push;
         cyc(2);
      end
      btn_push = 1'b1;
      cyc(20);
      check("s2_cnt_hold", nibble_cnt, 1);
      check("s2_word_hold", word_out, 32'h1);
      btn_push = 1'b0;
      cyc(20);
      check("s2_cnt_release", nibble_cnt, 1);

      // Partial entry then clear
      press_clear();
      check("s3_pre_clear", {word_out, 29'd0, nibble_cnt}, 64'd0);
      v0 = vld_count;
      press(4'hA);
      press(4'hB);
      press(4'hC);
      check("s3_word", word_out, 32'hABC);
      check("s3_cnt", nibble_cnt, 3);
      press_clear();
      check("s3_clr_word", word_out, 0);
      check("s3_clr_cnt", nibble_cnt, 0);
      check("s3_clr_addr", mem_addr, 1);
      check("s3_no_write", vld_count - v0, 0);

      // Back-pressure: request holds, pushes ignored
      mem_ready = 1'b0;
      sb_q.push_back({2'd1, 32'h12345678});
      enter_word(32'h12345678);
      for (int i = 0; i < 10; i++) begin
         check("s4_hold", {31'd0, mem_valid, mem_data},
               {31'd0, 1'b1, 32'h12345678});
         cyc(1);
      end
      press(4'hF);
      check("s4_word_kept", word_out, 32'h12345678);
      check("s4_cnt_kept", nibble_cnt, 0);
      check("s4_addr_kept", mem_addr, 1);
      mem_ready = 1'b1;
      cyc(2);
      check("s4_after_addr", mem_addr, 2);
      check("s4_after_word", word_out, 0);
      check("s4_after_valid", mem_valid, 0);

      // Fill the last two slots
      sb_q.push_back({2'd2, 32'hDEADBEEF});
      enter_word(32'hDEADBEEF);
      check("s5_addr2", {full, mem_addr}, {1'b0, 2'd3});
      sb_q.push_back({2'd3, 32'h0000CAFE});
      enter_word(32'h0000CAFE);
      check("s5_full", full, 1);
      check("s5_full_addr", mem_addr, 3);
      v0 = vld_count;
      press(4'h7);
      check("s5_blocked", {word_out, 29'd0, nibble_cnt}, 64'd0);
      check("s5_blocked_wr", vld_count - v0, 0);
      press_clear();
      check("s5_rearm_full", full, 0);
      check("s5_rearm_addr", mem_addr, 0);

      // Reset during a pending write
      mem_ready = 1'b0;
      enter_word(32'h00112233);
      check("s6_pending", {mem_valid, mem_data}, {1'b1, 32'h00112233});
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("s6_rst_ctl", {mem_valid, mem_addr, full, nibble_cnt}, 64'd0);
      check("s6_rst_data", {mem_data, word_out}, 64'd0);
      cyc(2);
      mem_ready = 1'b1;
      rst = 1'b0;
      cyc(4);
      check("s6_after_valid", mem_valid, 0);

      check("sb_empty", sb_q.size(), 0);
      check("hs_total", hs_count, 4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
